dram_arbiter: RTL
=================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requester ports (range 2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 24, DRAM word address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-004 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port p_req  input  NUM_PORTS  per-port request, level, held until p_ack.
REQ-007 SHALL have port p_we  input  NUM_PORTS  per-port 1=write, 0=read; stable while p_req.
REQ-008 SHALL have port p_addr  input  NUM_PORTS*ADDR_WIDTH  packed per-port address, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have port p_wdata  input  NUM_PORTS*DATA_WIDTH  packed per-port write data.
REQ-010 SHALL have port p_ack  output  NUM_PORTS  one-cycle completion pulse to the granted port.
REQ-011 SHALL have port p_rdata  output  DATA_WIDTH  read data, shared, valid in the p_ack cycle.
REQ-012 SHALL have port mem_addr  output  ADDR_WIDTH  address to SDRAM controller.
REQ-013 SHALL have port mem_req_read  output  1  read request level to controller.
REQ-014 SHALL have port mem_req_write  output  1  write request level to controller.
REQ-015 SHALL have port mem_wdata  output  DATA_WIDTH  write data to controller.
REQ-016 SHALL have port mem_rdata  input  DATA_WIDTH  read data from controller.
REQ-017 SHALL have port mem_done  input  1  one-cycle pulse: controller finished the current access (read data valid on mem_rdata in this cycle).

Function
REQ-018 SHALL implement states IDLE, BUSY, RESP; exactly one transaction outstanding.
REQ-019 IDLE: if any p_req sampled high, SHALL select winner, register grant index, addr, we, wdata, go BUSY; else stay IDLE.
REQ-020 BUSY: SHALL drive mem_req_read=~we or mem_req_write=we, mem_addr and mem_wdata from registered values, constant until mem_done.
REQ-021 On mem_done in BUSY: SHALL drop mem_req_* next cycle, capture mem_rdata into p_rdata, go RESP.
REQ-022 RESP: SHALL assert p_ack[grant] for exactly one cycle, then IDLE.
REQ-023 Latency: p_req sampled at edge N -> mem_req high after edge N; mem_done at edge M -> p_ack high after edge M for one cycle; back-to-back grants SHALL be spaced at least 3 cycles.
REQ-024 Default arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_PORTS; pointer updates only on p_ack.
REQ-025 A port still holding p_req in the cycle after its p_ack SHALL be treated as a new request.
REQ-026 mem_done outside BUSY SHALL be ignored; p_req changes of non-granted ports during BUSY SHALL not affect the transaction.
REQ-027 p_rdata SHALL hold its last value until the next read completes; unchanged on write completion.

Reset
REQ-028 While rst high: state IDLE, mem_req_read=0, mem_req_write=0, p_ack=0, mem_addr=0, mem_wdata=0, p_rdata=0, last_grant=NUM_PORTS-1 (so port 0 wins first).
REQ-029 Reset asserted mid-transaction SHALL abandon it immediately (mem_req_* low asynchronously); no p_ack issued for it.

Configuration
REQ-030 Macro DRAM_ARB_FIXED_PRIO_EN defined: port 0 SHALL win whenever requesting, remaining ports round-robin among themselves; undefined: pure round-robin per REQ-024.

Structure
REQ-031 Package dram_arb_pkg SHALL hold the state enum and default width constants (24, 32).
REQ-032 Winner selection SHALL be a sub-module rr_arbiter (req vector, pointer in; one-hot grant and index out; combinational).

Verification
REQ-033 Single read: port 1 req, addr 0x000123; controller returns 0xDEADBEEF with mem_done 4 cycles later -> mem_req_read high 1 cycle after req, p_ack[1] and p_rdata=0xDEADBEEF 1 cycle after mem_done.
REQ-034 Contention: ports 0 and 1 both held requesting for 4 transactions -> grant order 0,1,0,1 (macro undefined).
REQ-035 DRAM_ARB_FIXED_PRIO_EN, NUM_PORTS=3, all requesting continuously -> port 0 granted every transaction; with port 0 idle, order 1,2,1,2.
REQ-036 Write 0x00000055 to addr 0xFFFFFF -> mem_req_write high, mem_wdata=0x00000055, p_rdata unchanged after p_ack.
REQ-037 rst pulsed while BUSY -> mem_req_* low same cycle, no p_ack, next request granted to port 0.
REQ-038 Spurious mem_done in IDLE -> no p_ack, state remains IDLE.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared types and default sizes for the DRAM arbiter.
//
// Contents:
//   state_e       - arbiter FSM states (idle / memory access / acknowledge)
//   DefNumPorts   - default number of requester ports
//   DefAddrWidth  - default DRAM word address width
//   DefDataWidth  - default data word width
package dram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam int unsigned DefNumPorts  = 2;
    localparam int unsigned DefAddrWidth = 24;
    localparam int unsigned DefDataWidth = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational winner selection for the DRAM arbiter.
//
// Searches the request vector starting one past the last granted port and
// returns the first requester found, as a one-hot grant plus its index.
// With DRAM_ARB_FIXED_PRIO_EN defined, port 0 wins whenever it requests and
// the round-robin search only ever lands on the remaining ports.
//
// Ports:
//   req_i   - per-port request vector
//   ptr_i   - index of the last granted port
//   grant_o - one-hot grant (all zero when nobody requests)
//   idx_o   - index of the granted port (0 when nobody requests)
module rr_arbiter #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [IDX_W-1:0]     idx_o
);

    logic             found;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        grant_o  = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand_idx = '0;
`ifdef DRAM_ARB_FIXED_PRIO_EN
        if (req_i[0]) begin
            grant_o[0] = 1'b1;
            found      = 1'b1;
        end
`endif
        // i runs 1..NUM_PORTS so the last granted port is checked last.
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            cand_idx = IDX_W'((32'(ptr_i) + i) % NUM_PORTS);
            if (!found && req_i[cand_idx]) begin
                grant_o[cand_idx] = 1'b1;
                idx_o             = cand_idx;
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Multi-port arbiter in front of a single-access SDRAM controller.
//
// One transaction is outstanding at a time: IDLE picks a winner and latches
// its command, BUSY holds the memory request until mem_done, RESP pulses
// p_ack to the winner for one cycle. Read data is held on p_rdata until the
// next read completes.
//
// Build option: DRAM_ARB_FIXED_PRIO_EN gives port 0 absolute priority; the
// round-robin pointer then only tracks grants to the other ports.
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   p_req/p_we            - per-port request level and write flag
//   p_addr/p_wdata        - packed per-port address and write data
//   p_ack                 - one-cycle completion pulse to the granted port
//   p_rdata               - shared read data, valid with p_ack
//   mem_addr/mem_wdata    - command address and write data to the controller
//   mem_req_read/_write   - request levels to the controller
//   mem_rdata/mem_done    - controller read data and completion pulse
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = DefNumPorts,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            p_req,
    input  logic [NUM_PORTS-1:0]            p_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] p_wdata,
    output logic [NUM_PORTS-1:0]            p_ack,
    output logic [DATA_WIDTH-1:0]           p_rdata,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic                            mem_req_read,
    output logic                            mem_req_write,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    input  logic                            mem_done
);

    localparam int unsigned     IdxW     = $clog2(NUM_PORTS);
    localparam logic [IdxW-1:0] LastPort = IdxW'(NUM_PORTS - 1);

    state_e state_q, state_d;

    logic [IdxW-1:0]       grant_q;
    logic [IdxW-1:0]       last_grant_q, last_grant_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [NUM_PORTS-1:0]  win_onehot;
    logic [IdxW-1:0]       win_idx;
    logic                  any_req;

    // Unpacked views of the packed per-port buses.
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : gen_unpack
        assign addr_arr[g]  = p_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = p_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IdxW)
    ) u_rr_arbiter (
        .req_i   (p_req),
        .ptr_i   (last_grant_q),
        .grant_o (win_onehot),
        .idx_o   (win_idx)
    );

    assign any_req = |win_onehot;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req)  state_d = StBusy;
            StBusy:  if (mem_done) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        mem_req_read  = 1'b0;
        mem_req_write = 1'b0;
        p_ack         = '0;
        unique case (state_q)
            StBusy: begin
                mem_req_read  = ~we_q;
                mem_req_write = we_q;
            end
            StResp:  p_ack = NUM_PORTS'(1) << grant_q;
            default: ;
        endcase
    end

    // Pointer advances only when the acknowledge is issued, so an abandoned
    // transaction never moves it.
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == StResp) begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
            if (grant_q != '0) last_grant_d = grant_q;
`else
            last_grant_d = grant_q;
`endif
        end
    end

    // Command latch, read data capture and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q      <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            last_grant_q <= LastPort;
        end else begin
            if (state_q == StIdle && any_req) begin
                grant_q <= win_idx;
                we_q    <= p_we[win_idx];
                addr_q  <= addr_arr[win_idx];
                wdata_q <= wdata_arr[win_idx];
            end
            if (state_q == StBusy && mem_done && !we_q) begin
                rdata_q <= mem_rdata;
            end
            last_grant_q <= last_grant_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign p_rdata   = rdata_q;

endmodule
